// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ARM issue/writeback sequencer: ALU op codes,
// ARM opcode/condition values, FSM states and NZCV bit positions.
package alu_seq_pkg;

  localparam logic [4:0] ALU_AND  = 5'b00001;
  localparam logic [4:0] ALU_ORR  = 5'b00011;
  localparam logic [4:0] ALU_PASS = 5'b00100;
  localparam logic [4:0] ALU_EOR  = 5'b00101;
  localparam logic [4:0] ALU_ADD  = 5'b00111;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_ADC  = 5'b01001;
  localparam logic [4:0] ALU_SBC  = 5'b01010;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // TST/TEQ/CMP/CMN occupy 4'b10xx: flag-only, never written back
  function automatic logic is_compare(input logic [3:0] op);
    return (op[3:2] == 2'b10);
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition-field evaluation against an NZCV value.
module arm_cond_check
  import alu_seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // 4'b1111 falls to the default and never executes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer: one ARM data-processing instruction at a time,
// drives the external ALU, owns the NZCV register and presents the result.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_opcode,
  input  logic        in_s,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_shc,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_o,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_wr,
  output logic        out_exec,
  output logic [3:0]  flags,
  input  logic        msr_we,
  input  logic [3:0]  msr_flags
);

  state_t      state_r, state_next;
  logic [3:0]  cond_r, opcode_r, rd_r, flags_r, nzcv_s;
  logic        s_r, shc_r, pass_s, is_cmp_s, upd_s;
  logic [31:0] a_r, b_r;

  arm_cond_check u_cond (
    .cond (cond_r),
    .nzcv (flags_r),
    .pass (pass_s)
  );

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign flags     = flags_r;
  assign is_cmp_s  = is_compare(opcode_r);
  assign upd_s     = pass_s & (s_r | is_cmp_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: if (in_valid) state_next = ST_EXEC; else state_next = ST_IDLE;
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE; else state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outside EXEC the ALU sees a harmless pass of zero
  always_comb begin
    alu_op  = ALU_PASS;
    alu_a   = 32'h0;
    alu_b   = 32'h0;
    alu_cin = 1'b0;
    if (state_r == ST_EXEC) begin
      case (opcode_r)
        OP_AND, OP_TST: begin alu_op = ALU_AND;  alu_a = a_r;  alu_b = b_r;  end
        OP_EOR, OP_TEQ: begin alu_op = ALU_EOR;  alu_a = a_r;  alu_b = b_r;  end
        OP_SUB, OP_CMP: begin alu_op = ALU_SUB;  alu_a = a_r;  alu_b = b_r;  end
        OP_RSB:         begin alu_op = ALU_SUB;  alu_a = b_r;  alu_b = a_r;  end
        OP_ADD, OP_CMN: begin alu_op = ALU_ADD;  alu_a = a_r;  alu_b = b_r;  end
        OP_ADC: begin alu_op = ALU_ADC; alu_a = a_r; alu_b = b_r; alu_cin = flags_r[FLAG_C]; end
        OP_SBC: begin alu_op = ALU_SBC; alu_a = a_r; alu_b = b_r; alu_cin = ~flags_r[FLAG_C]; end
        OP_RSC: begin alu_op = ALU_SBC; alu_a = b_r; alu_b = a_r; alu_cin = ~flags_r[FLAG_C]; end
        OP_ORR:         begin alu_op = ALU_ORR;  alu_a = a_r;  alu_b = b_r;  end
        OP_MOV:         begin alu_op = ALU_PASS; alu_a = b_r;  end
        OP_BIC:         begin alu_op = ALU_AND;  alu_a = a_r;  alu_b = ~b_r; end
        OP_MVN:         begin alu_op = ALU_PASS; alu_a = ~b_r; end
        default:        begin alu_op = ALU_PASS; end
      endcase
    end else begin
      alu_op = ALU_PASS;
    end
  end

  // ALU reports borrow on subtracts, so ARM carry is its inverse there
  always_comb begin
    nzcv_s         = flags_r;
    nzcv_s[FLAG_N] = alu_o[31];
    nzcv_s[FLAG_Z] = (alu_o == 32'h0);
    case (opcode_r)
      OP_ADD, OP_ADC, OP_CMN: begin
        nzcv_s[FLAG_C] = alu_cout;
        nzcv_s[FLAG_V] = ~(alu_a[31] ^ alu_b[31]) & (alu_o[31] ^ alu_a[31]);
      end
      OP_SUB, OP_RSB, OP_SBC, OP_RSC, OP_CMP: begin
        nzcv_s[FLAG_C] = ~alu_cout;
        nzcv_s[FLAG_V] = (alu_a[31] ^ alu_b[31]) & (alu_o[31] ^ alu_a[31]);
      end
      default: begin
        nzcv_s[FLAG_C] = shc_r;
        nzcv_s[FLAG_V] = flags_r[FLAG_V];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cond_r     <= 4'h0;
      opcode_r   <= 4'h0;
      s_r        <= 1'b0;
      rd_r       <= 4'h0;
      a_r        <= 32'h0;
      b_r        <= 32'h0;
      shc_r      <= 1'b0;
      out_result <= 32'h0;
      out_rd     <= 4'h0;
      out_wr     <= 1'b0;
      out_exec   <= 1'b0;
      flags_r    <= 4'h0;
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        cond_r   <= in_cond;
        opcode_r <= in_opcode;
        s_r      <= in_s;
        rd_r     <= in_rd;
        a_r      <= in_a;
        b_r      <= in_b;
        shc_r    <= in_shc;
      end
      if (state_r == ST_EXEC) begin
        out_result <= alu_o;
        out_rd     <= rd_r;
        out_exec   <= pass_s;
        out_wr     <= pass_s & ~is_cmp_s;
      end
      // A sequencer flag update on the EXEC->DONE edge beats an MSR write
      if ((state_r == ST_EXEC) && upd_s) begin
        flags_r <= nzcv_s;
      end else if (msr_we) begin
        flags_r <= msr_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU neighbour plus an
// ARM-level reference model (wide signed/unsigned arithmetic) for results and flags.
module tb_alu_sequencer;

  logic        clk, reset, in_valid, in_ready, in_s, in_shc;
  logic [3:0]  in_cond, in_opcode, in_rd;
  logic [31:0] in_a, in_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_o;
  logic        alu_cin, alu_cout;
  logic        out_valid, out_ready, out_wr, out_exec;
  logic [31:0] out_result;
  logic [3:0]  out_rd, flags, msr_flags;
  logic        msr_we;

  int          checks = 0;
  int          failures = 0;
  logic [3:0]  mflags;
  logic [31:0] rnd, rnd2;
  logic [32:0] wide;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cond(in_cond), .in_opcode(in_opcode), .in_s(in_s), .in_rd(in_rd),
    .in_a(in_a), .in_b(in_b), .in_shc(in_shc),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_o(alu_o), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr(out_wr), .out_exec(out_exec), .flags(flags),
    .msr_we(msr_we), .msr_flags(msr_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU neighbour; cout is borrow for subtract codes
  always_comb begin
    alu_o    = 32'h0;
    alu_cout = 1'b0;
    wide     = 33'h0;
    case (alu_op)
      5'b00001: alu_o = alu_a & alu_b;
      5'b00011: alu_o = alu_a | alu_b;
      5'b00100: alu_o = alu_a;
      5'b00101: alu_o = alu_a ^ alu_b;
      5'b00111: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = wide[31:0]; alu_cout = wide[32]; end
      5'b01000: begin wide = {1'b0, alu_a} - {1'b0, alu_b}; alu_o = wide[31:0]; alu_cout = wide[32]; end
      5'b01001: begin wide = {1'b0, alu_a} + {1'b0, alu_b} + {32'h0, alu_cin}; alu_o = wide[31:0]; alu_cout = wide[32]; end
      5'b01010: begin wide = {1'b0, alu_a} - {1'b0, alu_b} - {32'h0, alu_cin}; alu_o = wide[31:0]; alu_cout = wide[32]; end
      default:  alu_o = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;           4'h1: return !z;
      4'h2: return c;           4'h3: return !c;
      4'h4: return n;           4'h5: return !n;
      4'h6: return v;           4'h7: return !v;
      4'h8: return c && !z;     4'h9: return !c || z;
      4'hA: return n == v;      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void alu_map(input logic [3:0] op, input logic c, output logic [4:0] eop, output logic ecin);
    ecin = 1'b0;
    case (op)
      4'h0, 4'h8, 4'hE: eop = 5'b00001;
      4'h1, 4'h9:       eop = 5'b00101;
      4'h2, 4'h3, 4'hA: eop = 5'b01000;
      4'h4, 4'hB:       eop = 5'b00111;
      4'h5:             begin eop = 5'b01001; ecin = c;  end
      4'h6, 4'h7:       begin eop = 5'b01010; ecin = !c; end
      4'hC:             eop = 5'b00011;
      default:          eop = 5'b00100;
    endcase
  endfunction

  // ARM semantics from exact 64-bit arithmetic: V iff the signed result does not fit 32 bits
  function automatic void arm_eval(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic shc, input logic [3:0] f,
                                   output logic [31:0] res, output logic [3:0] nf);
    logic [31:0] x, y;
    longint      ux, uy, k, t, sx, sy, sres, sext;
    int          kind;
    logic        c, v;
    kind = 0; x = a; y = b; k = 0; res = 32'h0; c = shc; v = f[0];
    case (op)
      4'h0, 4'h8: res = a & b;
      4'h1, 4'h9: res = a ^ b;
      4'hC:       res = a | b;
      4'hD:       res = b;
      4'hE:       res = a & ~b;
      4'hF:       res = ~b;
      4'h4, 4'hB: kind = 1;
      4'h5:       begin kind = 1; k = f[1] ? 1 : 0; end
      4'h2, 4'hA: kind = 2;
      4'h3:       begin kind = 2; x = b; y = a; end
      4'h6:       begin kind = 2; k = f[1] ? 0 : 1; end
      4'h7:       begin kind = 2; x = b; y = a; k = f[1] ? 0 : 1; end
      default:    kind = 0;
    endcase
    ux = 0; ux[31:0] = x;
    uy = 0; uy[31:0] = y;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (kind == 1) begin
      t = ux + uy + k; res = t[31:0]; c = t[32];
      sres = sx + sy + k;
    end else if (kind == 2) begin
      t = ux - uy - k; res = t[31:0]; c = (ux >= uy + k);
      sres = sx - sy - k;
    end else begin
      sres = 0;
    end
    sext = {{32{res[31]}}, res};
    if (kind != 0) v = (sres != sext);
    nf = {res[31], res == 32'h0, c, v};
  endfunction

  task automatic msr_write(input logic [3:0] val);
    @(negedge clk);
    msr_we = 1'b1; msr_flags = val;
    @(negedge clk);
    msr_we = 1'b0;
    mflags = val;
    chk("msr_idle_flags", 32'(flags), 32'(val));
  endtask

  task automatic run(input logic [3:0] cond, input logic [3:0] op, input logic s, input logic [3:0] rd,
                     input logic [31:0] a, input logic [31:0] b, input logic shc,
                     input int stall, input logic msr_en, input logic [3:0] msr_val);
    logic        pass, cmp, upd, ecin;
    logic [31:0] eres;
    logic [3:0]  enew, eflags;
    logic [4:0]  eop;
    pass = cond_ok(cond, mflags);
    cmp  = (op == 4'h8) || (op == 4'h9) || (op == 4'hA) || (op == 4'hB);
    arm_eval(op, a, b, shc, mflags, eres, enew);
    alu_map(op, mflags[1], eop, ecin);
    upd    = pass && (s || cmp);
    eflags = upd ? enew : (msr_en ? msr_val : mflags);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_cond = cond; in_opcode = op; in_s = s; in_rd = rd;
    in_a = a; in_b = b; in_shc = shc;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_opcode = ~op; in_shc = ~shc;
    chk("in_ready_exec", 32'(in_ready), 32'd0);
    chk("out_valid_exec", 32'(out_valid), 32'd0);
    chk("alu_op", 32'(alu_op), 32'(eop));
    chk("alu_cin", 32'(alu_cin), 32'(ecin));
    msr_we = msr_en; msr_flags = msr_val;
    out_ready = (stall == 0);
    @(negedge clk);
    msr_we = 1'b0;
    chk("out_valid_done", 32'(out_valid), 32'd1);
    chk("out_result", out_result, eres);
    chk("out_wr", 32'(out_wr), 32'(pass && !cmp));
    chk("out_exec", 32'(out_exec), 32'(pass));
    chk("out_rd", 32'(out_rd), 32'(rd));
    chk("flags", 32'(flags), 32'(eflags));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_result", out_result, eres);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_after_hs", 32'(out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(in_ready), 32'd1);
    mflags = eflags;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_cond = 4'h0; in_opcode = 4'h0; in_s = 1'b0;
    in_rd = 4'h0; in_a = 32'h0; in_b = 32'h0; in_shc = 1'b0;
    out_ready = 1'b1; msr_we = 1'b0; msr_flags = 4'h0; mflags = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_wr", 32'(out_wr), 32'd0);
    chk("rst_out_exec", 32'(out_exec), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd4);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_cin", 32'(alu_cin), 32'd0);

    run(4'hE, 4'h4, 1'b1, 4'd3, 32'h7FFFFFFF, 32'h1, 1'b0, 0, 1'b0, 4'h0);
    chk("adds_flags", 32'(flags), 32'b1001);
    chk("adds_result", out_result, 32'h80000000);
    run(4'hE, 4'hA, 1'b0, 4'd1, 32'd5, 32'd5, 1'b0, 0, 1'b0, 4'h0);
    chk("cmp_flags", 32'(flags), 32'b0110);
    msr_write(4'b0000);
    run(4'hE, 4'h6, 1'b0, 4'd2, 32'd10, 32'd3, 1'b0, 0, 1'b0, 4'h0);
    chk("sbc_c0", out_result, 32'd6);
    msr_write(4'b0010);
    run(4'hE, 4'h6, 1'b0, 4'd2, 32'd10, 32'd3, 1'b0, 0, 1'b0, 4'h0);
    chk("sbc_c1", out_result, 32'd7);
    msr_write(4'b0000);
    run(4'h0, 4'h4, 1'b1, 4'd4, 32'd1, 32'd2, 1'b0, 0, 1'b0, 4'h0);
    chk("addeq_exec", 32'(out_exec), 32'd0);
    run(4'h1, 4'hD, 1'b0, 4'd5, 32'd0, 32'hDEAD, 1'b0, 0, 1'b0, 4'h0);
    chk("movne_result", out_result, 32'hDEAD);
    run(4'hE, 4'hC, 1'b1, 4'd6, 32'h00F0, 32'h0F00, 1'b1, 5, 1'b0, 4'h0);
    run(4'hE, 4'h2, 1'b1, 4'd7, 32'h1234, 32'h1234, 1'b0, 0, 1'b1, 4'b0110);
    chk("subs_msr_flags", 32'(flags), 32'b0110);
    msr_write(4'b0000);
    run(4'hE, 4'h2, 1'b1, 4'd7, 32'h55, 32'h55, 1'b0, 0, 1'b1, 4'b1001);
    chk("subs_beats_msr", 32'(flags), 32'b0110);
    run(4'hE, 4'h4, 1'b0, 4'd8, 32'd1, 32'd1, 1'b0, 0, 1'b1, 4'b1010);
    chk("msr_no_update", 32'(flags), 32'b1010);
    run(4'hF, 4'hD, 1'b1, 4'd9, 32'd0, 32'h1, 1'b0, 0, 1'b0, 4'h0);
    chk("never_exec", 32'(out_exec), 32'd0);

    msr_write(4'b1111);
    @(negedge clk);
    in_valid = 1'b1; in_cond = 4'hE; in_opcode = 4'h4; in_s = 1'b1; in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_mid_exec", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_flags", 32'(flags), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("rst_mid_no_late", 32'(out_valid), 32'd0);
    mflags = 4'h0;

    for (int i = 0; i < 60; i++) begin
      rnd  = $urandom;
      rnd2 = $urandom;
      run(rnd[3:0], rnd[7:4], rnd[8], rnd[12:9], rnd2,
          (rnd[14:13] == 2'b00) ? rnd2 : $urandom, rnd[15],
          int'(rnd[17:16] == 2'b11 ? 2'd2 : rnd[17:16]), rnd[20:18] == 3'b000, rnd[24:21]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
